// File: rtl/halut_pkg.sv
// halut_pkg: shared types and helpers for the streaming HALUT encoder.
// Holds the encoder FSM state type, default/limit sizes and the heap
// offset helper used to address decision-tree thresholds.
package halut_pkg;

    typedef enum logic [1:0] {IDLE, WALK, DONE} enc_state_e;

    localparam int unsigned HalutDefaultK = 16;
    localparam int unsigned HalutMaxK = 256;
    localparam int unsigned HalutMaxTreeDepth = $clog2(HalutMaxK);

    // Heap layout: level l starts at index 2^l - 1, node counts within the level.
    function automatic int unsigned halut_node_offset(int unsigned level, int unsigned node);
        return (32'd1 << level) - 32'd1 + node;
    endfunction

endpackage

// File: rtl/halut_encoder_stream_if.sv
// halut_encoder_stream_if: input/output stream and threshold write bus of the encoder.
// master: feeder/consumer side; slave: encoder side.
//   enc_en            encoder enable (low = synchronous clear)
//   in_valid/in_ready input vector handshake, a_input = per-level features
//   waddr/wdata/we    threshold write port
//   out_valid/out_ready result handshake, c_addr/k_addr = result
interface halut_encoder_stream_if #(
    parameter int DataTypeWidth      = 16,
    parameter int TreeDepth          = 4,
    parameter int CAddrWidth         = 5,
    parameter int ThreshMemAddrWidth = 7
);
    logic                                    enc_en;
    logic                                    in_valid;
    logic                                    in_ready;
    logic [TreeDepth-1:0][DataTypeWidth-1:0] a_input;
    logic [ThreshMemAddrWidth-1:0]           waddr;
    logic [DataTypeWidth-1:0]                wdata;
    logic                                    we;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [CAddrWidth-1:0]                   c_addr;
    logic [TreeDepth-1:0]                    k_addr;

    modport master (
        output enc_en, in_valid, a_input, waddr, wdata, we, out_ready,
        input  in_ready, out_valid, c_addr, k_addr
    );

    modport slave (
        input  enc_en, in_valid, a_input, waddr, wdata, we, out_ready,
        output in_ready, out_valid, c_addr, k_addr
    );

endinterface

// File: rtl/fp_16_comparision.sv
// fp_16_comparision: IEEE fp16 greater-than, op_a_i > op_b_i -> gt_o.
// Any NaN operand yields 0; +0 and -0 compare equal (so yield 0).
module fp_16_comparision (
    input  logic [15:0] op_a_i,
    input  logic [15:0] op_b_i,
    output logic        gt_o
);

    logic a_nan, b_nan, both_zero;

    assign a_nan     = (&op_a_i[14:10]) && (|op_a_i[9:0]);
    assign b_nan     = (&op_b_i[14:10]) && (|op_b_i[9:0]);
    assign both_zero = ~(|op_a_i[14:0]) && ~(|op_b_i[14:0]);

    // Sign-magnitude: differing signs decide directly, equal signs compare
    // magnitudes, reversed for negative numbers.
    always_comb begin
        gt_o = (a_nan || b_nan || both_zero) ? 1'b0 :
               (op_a_i[15] != op_b_i[15])    ? op_b_i[15] :
               op_a_i[15]                    ? (op_a_i[14:0] < op_b_i[14:0]) :
                                               (op_a_i[14:0] > op_b_i[14:0]);
    end

endmodule

// File: rtl/halut_threshold_compare.sv
// halut_threshold_compare: a_i > b_i as fp16 (CompareFp16=1) or signed integer.
//   a_i feature, b_i threshold, gt_o decision bit.
module halut_threshold_compare #(
    parameter int DataTypeWidth = 16,
    parameter bit CompareFp16   = 1'b1
) (
    input  logic [DataTypeWidth-1:0] a_i,
    input  logic [DataTypeWidth-1:0] b_i,
    output logic                     gt_o
);

    if (CompareFp16) begin : g_fp
        fp_16_comparision u_fp (
            .op_a_i (a_i),
            .op_b_i (b_i),
            .gt_o   (gt_o)
        );
    end else begin : g_int
        assign gt_o = $signed(a_i) > $signed(b_i);
    end

endmodule

// File: rtl/scm.sv
// scm: register-file memory, synchronous write, asynchronous read.
//   clk_i clock; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port.
// A read of the address being written returns the old word.
module scm #(
    parameter int WordWidth = 16,
    parameter int NumWords  = 64,
    parameter int AddrWidth = 6
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [WordWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [WordWidth-1:0] rdata_o
);

    logic [WordWidth-1:0] mem_q [NumWords];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/halut_encoder_stream.sv
// halut_encoder_stream: streaming HALUT encoder walking a K-leaf decision tree.
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     slave side of halut_encoder_stream_if (input vector stream,
//           threshold write port, result stream of {c_addr, k_addr})
// One tree level is resolved per cycle; this instance serves codebooks
// EncUnitNumber + n*EncUnits and cycles through them one vector at a time.
module halut_encoder_stream import halut_pkg::*; #(
    parameter int K             = 16,
    parameter int C             = 32,
    parameter int EncUnits      = 4,
    parameter int EncUnitNumber = 0,
    parameter int DataTypeWidth = 16,
    parameter bit CompareFp16   = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    halut_encoder_stream_if.slave bus
);

    localparam int TreeDepth          = $clog2(K);
    localparam int CPerEncUnit        = C / EncUnits;
    localparam int CAddrWidth         = $clog2(C);
    localparam int ThreshMemAddrWidth = $clog2(CPerEncUnit * K);
    localparam int LevelWidth         = $clog2(TreeDepth);
    localparam int CLocalWidth        = (CPerEncUnit > 1) ? $clog2(CPerEncUnit) : 1;

    enc_state_e                              state_q, state_d;
    logic [LevelWidth-1:0]                   level_q, level_d;
    logic [TreeDepth-1:0]                    node_q, node_d;
    logic [CLocalWidth-1:0]                  c_local_q, c_local_d;
    logic [TreeDepth-1:0][DataTypeWidth-1:0] a_q, a_d;
    logic                                    out_valid_q, out_valid_d;
    logic [CAddrWidth-1:0]                   c_addr_q, c_addr_d;
    logic [TreeDepth-1:0]                    k_addr_q, k_addr_d;

    logic                          in_ready;
    logic                          last_level;
    logic                          bit_gt;
    logic [TreeDepth-1:0]          node_offset;
    logic [ThreshMemAddrWidth-1:0] raddr;
    logic [DataTypeWidth-1:0]      thresh;

    assign in_ready   = bus.enc_en && (state_q == IDLE) && !out_valid_q;
    assign last_level = level_q == LevelWidth'(TreeDepth - 1);
    // Offset never exceeds K-2, so TreeDepth bits are enough.
    assign node_offset = TreeDepth'(halut_node_offset(32'(level_q), 32'(node_q)));
    assign raddr = ThreshMemAddrWidth'(c_local_q) * ThreshMemAddrWidth'(K)
                 + ThreshMemAddrWidth'(node_offset);

    scm #(
        .WordWidth (DataTypeWidth),
        .NumWords  (CPerEncUnit * K),
        .AddrWidth (ThreshMemAddrWidth)
    ) u_thresh_mem (
        .clk_i   (clk_i),
        .we_i    (bus.we),
        .waddr_i (bus.waddr),
        .wdata_i (bus.wdata),
        .raddr_i (raddr),
        .rdata_o (thresh)
    );

    halut_threshold_compare #(
        .DataTypeWidth (DataTypeWidth),
        .CompareFp16   (CompareFp16)
    ) u_cmp (
        .a_i  (a_q[level_q]),
        .b_i  (thresh),
        .gt_o (bit_gt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            level_q     <= '0;
            node_q      <= '0;
            c_local_q   <= '0;
            a_q         <= '0;
            out_valid_q <= 1'b0;
            c_addr_q    <= CAddrWidth'(EncUnitNumber);
            k_addr_q    <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            node_q      <= node_d;
            c_local_q   <= c_local_d;
            a_q         <= a_d;
            out_valid_q <= out_valid_d;
            c_addr_q    <= c_addr_d;
            k_addr_q    <= k_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        node_d      = node_q;
        c_local_d   = c_local_q;
        a_d         = a_q;
        out_valid_d = out_valid_q;
        c_addr_d    = c_addr_q;
        k_addr_d    = k_addr_q;
        if (!bus.enc_en) begin
            // Disable drops any in-flight vector and restarts the codebook rotation.
            state_d     = IDLE;
            level_d     = '0;
            node_d      = '0;
            c_local_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready) begin
                        a_d     = bus.a_input;
                        level_d = '0;
                        node_d  = '0;
                        state_d = WALK;
                    end
                end
                WALK: begin
                    node_d = {node_q[TreeDepth-2:0], bit_gt};
                    if (last_level) begin
                        k_addr_d    = node_d;
                        c_addr_d    = CAddrWidth'(EncUnitNumber)
                                    + CAddrWidth'(c_local_q) * CAddrWidth'(EncUnits);
                        out_valid_d = 1'b1;
                        c_local_d   = (c_local_q == CLocalWidth'(CPerEncUnit - 1)) ? '0 : c_local_q + 1'b1;
                        state_d     = DONE;
                    end else begin
                        level_d = level_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.c_addr    = c_addr_q;
    assign bus.k_addr    = k_addr_q;

endmodule

// File: tb/tb_halut_encoder_stream.sv
// tb_halut_encoder_stream: directed self-checking bench for halut_encoder_stream.
// Three instances: main (K=16, signed, EncUnitNumber=1), big (K=256, signed)
// and fp (K=4, fp16 compare, EncUnitNumber=2).
module tb_halut_encoder_stream;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    halut_encoder_stream_if #(.DataTypeWidth(16), .TreeDepth(4), .CAddrWidth(5), .ThreshMemAddrWidth(7))  m_if ();
    halut_encoder_stream_if #(.DataTypeWidth(16), .TreeDepth(8), .CAddrWidth(5), .ThreshMemAddrWidth(11)) b_if ();
    halut_encoder_stream_if #(.DataTypeWidth(16), .TreeDepth(2), .CAddrWidth(3), .ThreshMemAddrWidth(3))  f_if ();

    halut_encoder_stream #(.K(16), .C(32), .EncUnits(4), .EncUnitNumber(1), .DataTypeWidth(16), .CompareFp16(1'b0)) u_main (
        .clk_i (clk), .rst_ni (rst_n), .bus (m_if)
    );
    halut_encoder_stream #(.K(256), .C(32), .EncUnits(4), .EncUnitNumber(0), .DataTypeWidth(16), .CompareFp16(1'b0)) u_big (
        .clk_i (clk), .rst_ni (rst_n), .bus (b_if)
    );
    halut_encoder_stream #(.K(4), .C(8), .EncUnits(4), .EncUnitNumber(2), .DataTypeWidth(16), .CompareFp16(1'b1)) u_fp (
        .clk_i (clk), .rst_ni (rst_n), .bus (f_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_m(input int a, input logic [15:0] d);
        m_if.waddr = 7'(a); m_if.wdata = d; m_if.we = 1'b1;
        tick();
        m_if.we = 1'b0;
    endtask

    task automatic wr_b(input int a, input logic [15:0] d);
        b_if.waddr = 11'(a); b_if.wdata = d; b_if.we = 1'b1;
        tick();
        b_if.we = 1'b0;
    endtask

    task automatic wr_f(input int a, input logic [15:0] d);
        f_if.waddr = 3'(a); f_if.wdata = d; f_if.we = 1'b1;
        tick();
        f_if.we = 1'b0;
    endtask

    task automatic start_m(input logic [63:0] a, input string tag);
        m_if.a_input = a;
        m_if.in_valid = 1'b1;
        chk({tag, " in_ready"}, 32'(m_if.in_ready), 32'd1);
        tick();
        m_if.in_valid = 1'b0;
    endtask

    task automatic wait_m(output int lat);
        lat = 0;
        while (!m_if.out_valid && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic vec_m(input logic [63:0] a, input int exp_k, input int exp_c, input string tag);
        int lat;
        start_m(a, tag);
        wait_m(lat);
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " k_addr"}, 32'(m_if.k_addr), 32'(exp_k));
        chk({tag, " c_addr"}, 32'(m_if.c_addr), 32'(exp_c));
        tick();
        chk({tag, " out_valid clear"}, 32'(m_if.out_valid), 32'd0);
    endtask

    task automatic vec_b(input logic [127:0] a, input int exp_k, input int exp_c, input string tag);
        int lat;
        b_if.a_input = a;
        b_if.in_valid = 1'b1;
        chk({tag, " in_ready"}, 32'(b_if.in_ready), 32'd1);
        tick();
        b_if.in_valid = 1'b0;
        lat = 0;
        while (!b_if.out_valid && lat < 64) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd8);
        chk({tag, " k_addr"}, 32'(b_if.k_addr), 32'(exp_k));
        chk({tag, " c_addr"}, 32'(b_if.c_addr), 32'(exp_c));
        tick();
        chk({tag, " out_valid clear"}, 32'(b_if.out_valid), 32'd0);
    endtask

    task automatic vec_f(input logic [31:0] a, input int exp_k, input int exp_c, input string tag);
        int lat;
        f_if.a_input = a;
        f_if.in_valid = 1'b1;
        chk({tag, " in_ready"}, 32'(f_if.in_ready), 32'd1);
        tick();
        f_if.in_valid = 1'b0;
        lat = 0;
        while (!f_if.out_valid && lat < 64) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd2);
        chk({tag, " k_addr"}, 32'(f_if.k_addr), 32'(exp_k));
        chk({tag, " c_addr"}, 32'(f_if.c_addr), 32'(exp_c));
        tick();
        chk({tag, " out_valid clear"}, 32'(f_if.out_valid), 32'd0);
    endtask

    localparam logic [15:0] P5 = 16'd5;
    localparam logic [15:0] M1 = 16'hFFFF;

    initial begin
        int lat;
        logic [7:0][15:0] big_a;
        m_if.enc_en = 1'b0; m_if.in_valid = 1'b0; m_if.a_input = '0; m_if.waddr = '0; m_if.wdata = '0; m_if.we = 1'b0; m_if.out_ready = 1'b1;
        b_if.enc_en = 1'b0; b_if.in_valid = 1'b0; b_if.a_input = '0; b_if.waddr = '0; b_if.wdata = '0; b_if.we = 1'b0; b_if.out_ready = 1'b1;
        f_if.enc_en = 1'b0; f_if.in_valid = 1'b0; f_if.a_input = '0; f_if.waddr = '0; f_if.wdata = '0; f_if.we = 1'b0; f_if.out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(m_if.in_ready), 32'd0);
        chk("reset out_valid", 32'(m_if.out_valid), 32'd0);
        chk("reset c_addr", 32'(m_if.c_addr), 32'd1);
        chk("reset k_addr", 32'(m_if.k_addr), 32'd0);
        chk("reset fp c_addr", 32'(f_if.c_addr), 32'd2);
        rst_n = 1'b1;
        m_if.enc_en = 1'b1; b_if.enc_en = 1'b1; f_if.enc_en = 1'b1;
        for (int i = 0; i < 128; i++) wr_m(i, 16'd0);
        // codebook slot 3, heap node 2 (level 1, node 1)
        wr_m(3 * 16 + 2, 16'd100);
        vec_m({P5, P5, P5, P5}, 15, 1, "all_pos");
        vec_m({M1, M1, M1, M1}, 0, 5, "all_neg");
        vec_m({16'd0, 16'd0, 16'd0, 16'd0}, 0, 9, "equal");
        vec_m({16'd1, 16'd1, 16'd50, 16'd1}, 11, 13, "heap");
        vec_m({P5, P5, P5, P5}, 15, 17, "c4");
        vec_m({P5, M1, P5, M1}, 5, 21, "c5");
        vec_m({P5, P5, P5, P5}, 15, 25, "c6");
        vec_m({M1, M1, P5, P5}, 12, 29, "c7");
        vec_m({P5, P5, P5, P5}, 15, 1, "c_wrap");
        // backpressure
        m_if.out_ready = 1'b0;
        start_m({P5, P5, P5, M1}, "bp");
        wait_m(lat);
        chk("bp latency", 32'(lat), 32'd4);
        m_if.in_valid = 1'b1;
        m_if.a_input = {P5, P5, P5, P5};
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp out_valid", 32'(m_if.out_valid), 32'd1);
            chk("bp k_addr", 32'(m_if.k_addr), 32'd7);
            chk("bp c_addr", 32'(m_if.c_addr), 32'd5);
            chk("bp in_ready", 32'(m_if.in_ready), 32'd0);
        end
        m_if.in_valid = 1'b0;
        m_if.out_ready = 1'b1;
        tick();
        chk("bp release", 32'(m_if.out_valid), 32'd0);
        vec_m({P5, P5, P5, P5}, 15, 9, "after_bp");
        // enable drop mid-walk
        start_m({P5, P5, P5, P5}, "drop");
        tick();
        tick();
        m_if.enc_en = 1'b0;
        tick();
        chk("drop out_valid", 32'(m_if.out_valid), 32'd0);
        chk("drop in_ready", 32'(m_if.in_ready), 32'd0);
        m_if.enc_en = 1'b1;
        #1;
        chk("drop idle in_ready", 32'(m_if.in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("drop no result", 32'(m_if.out_valid), 32'd0);
        end
        vec_m({P5, P5, P5, P5}, 15, 1, "after_drop");
        // reset while holding a result
        m_if.out_ready = 1'b0;
        start_m({P5, P5, P5, P5}, "rst");
        wait_m(lat);
        chk("rst held c_addr", 32'(m_if.c_addr), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", 32'(m_if.out_valid), 32'd0);
        chk("rst c_addr", 32'(m_if.c_addr), 32'd1);
        chk("rst k_addr", 32'(m_if.k_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        m_if.out_ready = 1'b1;
        vec_m({M1, P5, M1, P5}, 10, 1, "after_rst");
        // K=256 variant
        for (int i = 0; i < 256; i++) wr_b(i, 16'd0);
        for (int l = 0; l < 8; l++) big_a[l] = (l % 2 == 0) ? P5 : M1;
        vec_b(big_a, 170, 0, "k256");
        // fp16 variant: slot 0 thresholds 0.5, slot 1 thresholds -0 / -2.0
        wr_f(0, 16'h3800); wr_f(1, 16'h3800); wr_f(2, 16'h3800);
        wr_f(4, 16'h8000); wr_f(5, 16'hC000); wr_f(6, 16'hC000);
        vec_f({16'h7E00, 16'h3C00}, 2, 2, "fp_nan");
        vec_f({16'hBC00, 16'h0000}, 1, 6, "fp_zero_neg");
        vec_f({16'h3C00, 16'h3C00}, 3, 2, "fp_pos");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
